// File: rtl/lfm_pulse_gater_if.sv
// Stream bundle between the LFM DDS output and the pulse gater / DAC path.
// The slave view is the gater itself; the master view drives samples and observes the framed output.
interface lfm_pulse_gater_if;
  logic        s_valid;
  logic [31:0] s_data;
  logic        m_valid;
  logic [31:0] m_data;
  logic        m_first;
  logic        m_last;
  logic        pulse_active;
  logic [15:0] pulse_count;

  modport slave (
    input  s_valid, s_data,
    output m_valid, m_data, m_first, m_last, pulse_active, pulse_count
  );

  modport master (
    output s_valid, s_data,
    input  m_valid, m_data, m_first, m_last, pulse_active, pulse_count
  );
endinterface

// File: rtl/lfm_pulse_gater.sv
// Cuts a continuous LFM chirp into tapered radar pulses on a PRI grid.
// Two-stage pipeline: stage 1 latches sample/gain/flags, stage 2 multiplies and shifts per I/Q lane.

module lfm_gain_lane #(
  parameter int VEC_W = 16,
  parameter int SH    = 4,
  parameter int GW    = SH + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [VEC_W-1:0] x,
  input  logic [GW-1:0]    g,
  output logic [VEC_W-1:0] y
);
  localparam int PW = VEC_W + SH + 2;

  logic signed [PW-1:0] prod;

  // g <= 2^SH, so the shifted product always fits back into VEC_W bits
  assign prod = $signed({{(PW-VEC_W){x[VEC_W-1]}}, x}) * $signed({{(PW-GW){1'b0}}, g});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) y <= '0;
    else       y <= en ? VEC_W'(prod >>> SH) : '0;
  end
endmodule

module lfm_pulse_gater #(
  parameter int PULSE_LEN = 1024,
  parameter int PRI_LEN   = 4096,
  parameter int RAMP_LOG2 = 4,
  parameter int NUM_LANES = 2,
  parameter int VEC_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  lfm_pulse_gater_if.slave  bus
);
  localparam int R      = 1 << RAMP_LOG2;
  localparam int GW     = RAMP_LOG2 + 1;
  localparam int NW     = (PRI_LEN > 2) ? $clog2(PRI_LEN) : 1;
  localparam int STAGES = 2;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_RAMP_UP   = 3'd1;
  localparam logic [2:0] S_FLAT      = 3'd2;
  localparam logic [2:0] S_RAMP_DOWN = 3'd3;
  localparam logic [2:0] S_GAP       = 3'd4;

  logic [2:0]        state;
  logic [NW-1:0]     n, n_inc;
  logic              accept;
  logic [STAGES:0]   vld_pipe;
  logic [GW-1:0]     gain;

  logic [NUM_LANES-1:0][VEC_W-1:0] s1_data;
  logic [NUM_LANES-1:0][VEC_W-1:0] s2_data;
  logic [GW-1:0]     s1_gain;
  logic              s1_first, s1_last, s1_active;
  logic              m_first_r, m_last_r, m_active_r;
  logic [15:0]       cnt;

  function automatic logic [2:0] state_of(input logic [NW-1:0] idx);
    if (int'(idx) < R)                  return S_RAMP_UP;
    else if (int'(idx) < PULSE_LEN - R) return S_FLAT;
    else if (int'(idx) < PULSE_LEN)     return S_RAMP_DOWN;
    else                                return S_GAP;
  endfunction

  // In IDLE the accepted sample is n=0 of a new pulse (n is held at 0 there)
  assign accept      = bus.s_valid && ((state != S_IDLE) || enable);
  assign vld_pipe[0] = accept;
  assign n_inc       = n + NW'(1);

  always_comb begin
    gain = '0;
    case (state)
      S_RAMP_UP:   gain = GW'(n);
      S_FLAT:      gain = GW'(R);
      S_RAMP_DOWN: gain = GW'(PULSE_LEN - 1 - int'(n));
      default:     gain = '0;
    endcase
  end

  // enable only matters at the PRI boundary, so pulses and gaps always finish
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      n     <= '0;
    end else if (accept) begin
      if (n == NW'(PRI_LEN - 1)) begin
        n     <= '0;
        state <= enable ? S_RAMP_UP : S_IDLE;
      end else begin
        n     <= n_inc;
        state <= state_of(n_inc);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe[STAGES:1] <= '0;
      s1_data   <= '0;
      s1_gain   <= '0;
      s1_first  <= 1'b0;
      s1_last   <= 1'b0;
      s1_active <= 1'b0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      if (accept) begin
        s1_data   <= bus.s_data;
        s1_gain   <= gain;
        s1_first  <= (n == '0);
        s1_last   <= (n == NW'(PULSE_LEN - 1));
        s1_active <= (int'(n) < PULSE_LEN);
      end
    end
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    lfm_gain_lane #(.VEC_W(VEC_W), .SH(RAMP_LOG2), .GW(GW)) u_lane (
      .clk   (clk),
      .reset (reset),
      .en    (vld_pipe[1]),
      .x     (s1_data[l]),
      .g     (s1_gain),
      .y     (s2_data[l])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_first_r  <= 1'b0;
      m_last_r   <= 1'b0;
      m_active_r <= 1'b0;
      cnt        <= '0;
    end else begin
      m_first_r  <= vld_pipe[1] & s1_first;
      m_last_r   <= vld_pipe[1] & s1_last;
      m_active_r <= vld_pipe[1] & s1_active;
      if (vld_pipe[1] && s1_first) cnt <= cnt + 16'd1;
    end
  end

  assign bus.m_valid      = vld_pipe[STAGES];
  assign bus.m_data       = s2_data;
  assign bus.m_first      = m_first_r;
  assign bus.m_last       = m_last_r;
  assign bus.pulse_active = m_active_r;
  assign bus.pulse_count  = cnt;
endmodule

// File: tb/tb_lfm_pulse_gater.sv
// Bench for lfm_pulse_gater: spec-level reference model on every cycle, constant
// vector table for taper points, and directed reset / enable-drop sequences.
module tb_lfm_pulse_gater;
  localparam int P   = 64;
  localparam int PRI = 128;
  localparam int RL  = 3;
  localparam int R   = 1 << RL;

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
    logic        fst;
    logic        lst;
    logic        act;
    logic [15:0] cnt;
  } out_t;

  typedef struct {
    int   stim;
    int   n;
    out_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic enable;
  lfm_pulse_gater_if bus();

  lfm_pulse_gater #(.PULSE_LEN(P), .PRI_LEN(PRI), .RAMP_LOG2(RL)) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int   tests = 0;
  int   fails = 0;
  out_t exp_q[$];
  bit   m_busy;
  int   m_n;
  logic [15:0] m_cnt;
  int   cur_run;
  int   vcnt;
  out_t cap[4][256];
  vec_t vecs[16];

  function automatic out_t mk(logic v, logic [31:0] d, logic f, logic l, logic a, logic [15:0] c);
    out_t o;
    o.valid = v; o.data = d; o.fst = f; o.lst = l; o.act = a; o.cnt = c;
    return o;
  endfunction

  function automatic out_t sample();
    return mk(bus.m_valid, bus.m_data, bus.m_first, bus.m_last, bus.pulse_active, bus.pulse_count);
  endfunction

  // floor(x*g/R) by plain integer division with explicit rounding toward -inf
  function automatic logic [15:0] taper(logic [15:0] x, int g);
    int p, q;
    logic [15:0] r;
    p = int'($signed(x)) * g;
    q = p / R;
    if ((p % R != 0) && (p < 0)) q = q - 1;
    r = 16'(q);
    return r;
  endfunction

  function automatic int gain_of(int idx);
    if (idx < R)          return idx;
    else if (idx < P - R) return R;
    else if (idx < P)     return P - 1 - idx;
    else                  return 0;
  endfunction

  task automatic check(input string nm, input out_t got_in, input out_t exp);
    out_t got;
    got = got_in;
    if (!exp.valid) got.data = exp.data;
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got v=%0b d=%h f=%0b l=%0b a=%0b c=%0d, want v=%0b d=%h f=%0b l=%0b a=%0b c=%0d",
               nm, got_in.valid, got_in.data, got_in.fst, got_in.lst, got_in.act, got_in.cnt,
               exp.valid, exp.data, exp.fst, exp.lst, exp.act, exp.cnt);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_n    = 0;
    m_cnt  = '0;
    exp_q.delete();
    exp_q.push_back(mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 16'd0));
  endtask

  task automatic model_accept(input logic v, input logic en, input logic [31:0] d);
    out_t e;
    int   g;
    e = '0;
    if (v) begin
      if (!m_busy && en) begin
        m_busy = 1'b1;
        m_n    = 0;
      end
      if (m_busy) begin
        g = gain_of(m_n);
        if (m_n == 0) m_cnt = m_cnt + 16'd1;
        e.valid = 1'b1;
        e.data  = {taper(d[31:16], g), taper(d[15:0], g)};
        e.fst   = (m_n == 0);
        e.lst   = (m_n == P - 1);
        e.act   = (m_n < P);
        if (m_n == PRI - 1) begin
          m_n    = 0;
          m_busy = en;
        end else begin
          m_n++;
        end
      end
    end
    e.cnt = m_cnt;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic v, input logic en, input logic [31:0] d);
    out_t got;
    bus.s_valid = v;
    bus.s_data  = d;
    enable      = en;
    @(posedge clk);
    model_accept(v, en, d);
    #1;
    got = sample();
    check("model", got, exp_q.pop_front());
    if (got.valid) begin
      if (cur_run >= 0 && vcnt < 256) cap[cur_run][vcnt] = got;
      vcnt++;
    end
  endtask

  task automatic do_reset(input int run);
    reset       = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    enable      = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_state", sample(), '0);
    model_reset();
    cur_run = run;
    vcnt    = 0;
    reset   = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{0,   0, mk(1, 32'h00000000, 1, 0, 1, 1)};
    vecs[1]  = '{0,   1, mk(1, 32'hF8000800, 0, 0, 1, 1)};
    vecs[2]  = '{0,   8, mk(1, 32'hC0004000, 0, 0, 1, 1)};
    vecs[3]  = '{0,  30, mk(1, 32'hC0004000, 0, 0, 1, 1)};
    vecs[4]  = '{0,  55, mk(1, 32'hC0004000, 0, 0, 1, 1)};
    vecs[5]  = '{0,  56, mk(1, 32'hC8003800, 0, 0, 1, 1)};
    vecs[6]  = '{0,  63, mk(1, 32'h00000000, 0, 1, 1, 1)};
    vecs[7]  = '{0,  64, mk(1, 32'h00000000, 0, 0, 0, 1)};
    vecs[8]  = '{0, 127, mk(1, 32'h00000000, 0, 0, 0, 1)};
    vecs[9]  = '{0, 128, mk(1, 32'h00000000, 1, 0, 1, 2)};
    vecs[10] = '{1,   1, mk(1, 32'h0FFFF000, 0, 0, 1, 1)};
    vecs[11] = '{1,   7, mk(1, 32'h6FFF9000, 0, 0, 1, 1)};
    vecs[12] = '{1,   8, mk(1, 32'h7FFF8000, 0, 0, 1, 1)};
    vecs[13] = '{1,  40, mk(1, 32'h7FFF8000, 0, 0, 1, 1)};
    vecs[14] = '{1,  62, mk(1, 32'h0FFFF000, 0, 0, 1, 1)};
    vecs[15] = '{1,  63, mk(1, 32'h00000000, 0, 1, 1, 1)};

    cur_run = -1;
    vcnt    = 0;
    model_reset();

    // Constant input, valid every cycle
    do_reset(0);
    for (int i = 0; i < 135; i++) step(1'b1, 1'b1, 32'hC0004000);

    // Negative full scale I, positive full scale Q
    do_reset(1);
    for (int i = 0; i < 70; i++) step(1'b1, 1'b1, 32'h7FFF8000);

    // Same as the constant run, with a bubble every other cycle
    do_reset(2);
    for (int i = 0; i < 290; i++) step(logic'(i % 2 == 0), 1'b1, 32'hC0004000);

    for (int r = 0; r < 3; r++)
      for (int i = 0; i < 16; i++)
        if (vecs[i].stim == ((r == 1) ? 1 : 0))
          check($sformatf("vec r%0d n%0d", r, vecs[i].n), cap[r][vecs[i].n], vecs[i].exp);

    // enable dropped at n=30: pulse and gap finish, then the stream goes idle
    do_reset(3);
    for (int i = 0; i < 30; i++) step(1'b1, 1'b1, 32'h12345678);
    for (int i = 0; i < 200; i++) step(1'b1, 1'b0, 32'h12345678);
    tests++;
    if (vcnt != PRI) begin
      fails++;
      $display("FAIL enable_drop_len: got %0d valid outputs, want %0d", vcnt, PRI);
    end
    check("enable_drop_idle", sample(), mk(0, 32'h0, 0, 0, 0, 1));

    // Asynchronous reset mid-FLAT, then restart
    do_reset(-1);
    for (int i = 0; i < 22; i++) step(1'b1, 1'b1, 32'hC0004000);
    #2 reset = 1'b1;
    #1 check("async_reset", sample(), '0);
    do_reset(-1);
    step(1'b1, 1'b1, 32'hC0004000);
    step(1'b1, 1'b1, 32'hC0004000);
    check("post_reset_first", sample(), mk(1, 32'h0, 1, 0, 1, 1));
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 32'hC0004000);

    // Random data, valid and enable
    do_reset(-1);
    for (int i = 0; i < 3000; i++)
      step(logic'($urandom_range(0, 99) < 70), logic'($urandom_range(0, 99) < 90), $urandom);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
